inertial_integrator_cal: RTL and testbench

Parametrised pitch complementary filter (gyro integration plus accelerometer leak) with a start-up bias-calibration state machine. After reset the block averages 2^CAL_LOG2 valid samples of pitch rate and AZ to learn both sensor offsets. It then integrates with those learned offsets and saturates the accumulator instead of letting it wrap. It sits between the inertial sensor SPI front end and the balance controller, and replaces the fixed-offset integrator.

---
 rtl/inertial_integrator_cal.sv | 157 +++++++++++++++
 tb/tb_inertial_integrator_cal.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inertial_integrator_cal.sv
// Pitch complementary filter: gyro integration with accelerometer leak, preceded by a
// start-up calibration that averages 2^CAL_LOG2 samples to learn both sensor offsets.
module inertial_integrator_cal #(
  parameter int unsigned       DATA_W          = 16,
  parameter int unsigned       FRAC_W          = 11,
  parameter int unsigned       CAL_LOG2        = 9,
  parameter int unsigned       FUSION_GAIN     = 1024,
  parameter int unsigned       ACC_SCALE       = 327,
  parameter int unsigned       ACC_SHIFT       = 13,
  parameter logic [DATA_W-1:0] PTCH_RT_OFF_DEF = 16'h0050,
  parameter logic [DATA_W-1:0] AZ_OFF_DEF      = 16'h00A0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [DATA_W-1:0] ptch_rt,
  input  logic [DATA_W-1:0] AZ,
  input  logic              cal_req,
  output logic [DATA_W-1:0] ptch,
  output logic              ptch_vld,
  output logic              cal_done,
  output logic              sat,
  output logic [DATA_W-1:0] ptch_rt_off,
  output logic [DATA_W-1:0] AZ_off
);

  localparam int unsigned AccW = DATA_W + FRAC_W;
  localparam int unsigned NxtW = AccW + 2;
  localparam int unsigned SumW = DATA_W + CAL_LOG2;

  localparam logic signed [NxtW-1:0]   AccMax = {{3{1'b0}}, {(AccW-1){1'b1}}};
  localparam logic signed [NxtW-1:0]   AccMin = {{3{1'b1}}, {(AccW-1){1'b0}}};
  localparam logic signed [NxtW-1:0]   Gain   = NxtW'(FUSION_GAIN);
  localparam logic signed [DATA_W-1:0] Scale  = DATA_W'(ACC_SCALE);

  typedef enum logic [0:0] {StCal, StRun} state_e;

  state_e                   state_q, state_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic [CAL_LOG2-1:0]      cnt_q, cnt_d;
  logic signed [SumW-1:0]   sum_rt_q, sum_rt_d, sum_az_q, sum_az_d;
  logic [DATA_W-1:0]        rt_off_q, rt_off_d, az_off_q, az_off_d;
  logic                     ptch_vld_q, ptch_vld_d;
  logic                     sat_q, sat_d;

  logic signed [DATA_W-1:0]   rt_s, az_s;
  logic signed [SumW-1:0]     sum_rt_inc, sum_az_inc;
  logic signed [DATA_W-1:0]   rt_comp, az_comp, ptch_acc, ptch_cur;
  logic signed [2*DATA_W-1:0] az_prod;
  logic signed [NxtW-1:0]     acc_ext, rt_ext, leak, nxt;
  logic signed [AccW-1:0]     acc_clamped;
  logic                       ovf;

  assign rt_s       = ptch_rt;
  assign az_s       = AZ;
  assign sum_rt_inc = sum_rt_q + rt_s;
  assign sum_az_inc = sum_az_q + az_s;

  // Offset-compensated inputs wrap at DATA_W by design.
  assign rt_comp  = ptch_rt - rt_off_q;
  assign az_comp  = AZ - az_off_q;
  assign az_prod  = az_comp * Scale;
  assign ptch_acc = DATA_W'(az_prod >>> ACC_SHIFT);
  assign ptch_cur = acc_q[AccW-1:FRAC_W];

  // Headroom of two bits lets the clamp see overflow in either direction.
  assign acc_ext = acc_q;
  assign rt_ext  = rt_comp;
  assign leak    = (ptch_acc > ptch_cur) ? Gain : -Gain;
  assign nxt     = acc_ext - rt_ext + leak;

  always_comb begin
    acc_clamped = nxt[AccW-1:0];
    ovf         = 1'b0;
    if (nxt > AccMax) begin
      acc_clamped = AccMax[AccW-1:0];
      ovf         = 1'b1;
    end else if (nxt < AccMin) begin
      acc_clamped = AccMin[AccW-1:0];
      ovf         = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum_rt_d   = sum_rt_q;
    sum_az_d   = sum_az_q;
    rt_off_d   = rt_off_q;
    az_off_d   = az_off_q;
    ptch_vld_d = 1'b0;
    sat_d      = 1'b0;
    if (cal_req) begin
      // Offsets are kept until the restarted calibration completes.
      state_d  = StCal;
      acc_d    = '0;
      cnt_d    = '0;
      sum_rt_d = '0;
      sum_az_d = '0;
    end else if (vld) begin
      unique case (state_q)
        StCal: begin
          cnt_d    = cnt_q + 1'b1;
          sum_rt_d = sum_rt_inc;
          sum_az_d = sum_az_inc;
          if (cnt_q == '1) begin
            rt_off_d = DATA_W'(sum_rt_inc >>> CAL_LOG2);
            az_off_d = DATA_W'(sum_az_inc >>> CAL_LOG2);
            sum_rt_d = '0;
            sum_az_d = '0;
            acc_d    = '0;
            state_d  = StRun;
          end
        end
        StRun: begin
          acc_d      = acc_clamped;
          sat_d      = ovf;
          ptch_vld_d = 1'b1;
        end
        default: state_d = StCal;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCal;
      acc_q      <= '0;
      cnt_q      <= '0;
      sum_rt_q   <= '0;
      sum_az_q   <= '0;
      rt_off_q   <= PTCH_RT_OFF_DEF;
      az_off_q   <= AZ_OFF_DEF;
      ptch_vld_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sum_rt_q   <= sum_rt_d;
      sum_az_q   <= sum_az_d;
      rt_off_q   <= rt_off_d;
      az_off_q   <= az_off_d;
      ptch_vld_q <= ptch_vld_d;
      sat_q      <= sat_d;
    end
  end

  assign ptch        = acc_q[AccW-1:FRAC_W];
  assign ptch_vld    = ptch_vld_q;
  assign cal_done    = (state_q == StRun);
  assign sat         = sat_q;
  assign ptch_rt_off = rt_off_q;
  assign AZ_off      = az_off_q;

endmodule

// File: tb/tb_inertial_integrator_cal.sv
// Directed bench for inertial_integrator_cal with a 4-sample calibration window.
module tb_inertial_integrator_cal;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        cal_req;
  logic [15:0] ptch;
  logic        ptch_vld;
  logic        cal_done;
  logic        sat;
  logic [15:0] ptch_rt_off;
  logic [15:0] AZ_off;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inertial_integrator_cal #(
    .CAL_LOG2(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vld        (vld),
    .ptch_rt    (ptch_rt),
    .AZ         (AZ),
    .cal_req    (cal_req),
    .ptch       (ptch),
    .ptch_vld   (ptch_vld),
    .cal_done   (cal_done),
    .sat        (sat),
    .ptch_rt_off(ptch_rt_off),
    .AZ_off     (AZ_off)
  );

  typedef struct {
    logic [15:0] rt;
    logic [15:0] az;
    int          acc;
    logic [15:0] ptch;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] acc_now();
    return {{5{dut.acc_q[26]}}, dut.acc_q};
  endfunction

  task automatic pulse_vld(input logic [15:0] rt, input logic [15:0] az);
    ptch_rt = rt;
    AZ      = az;
    vld     = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  task automatic pulse_cal_req(input logic with_vld);
    cal_req = 1'b1;
    vld     = with_vld;
    ptch_rt = 16'h1000;
    AZ      = 16'h1000;
    @(posedge clk);
    #1;
    cal_req = 1'b0;
    vld     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic seen_vld;
    logic seen_sat;
    logic [15:0] held;
    int bad;

    vecs[0] = '{16'h0050, 16'h00A0, -1024,  16'hFFFF};
    vecs[1] = '{16'h0050, 16'h00A0, 0,      16'h0000};
    vecs[2] = '{16'h0050, 16'h00A0, -1024,  16'hFFFF};
    vecs[3] = '{16'hFF50, 16'h00A0, 256,    16'h0000};
    vecs[4] = '{16'h0850, 16'h0488, -768,   16'hFFFF};
    vecs[5] = '{16'hC050, 16'hFCB8, 14592,  16'h0007};
    vecs[6] = '{16'h0050, 16'h0870, 15616,  16'h0007};
    vecs[7] = '{16'h7050, 16'h00A0, -14080, 16'hFFF9};
    vecs[8] = '{16'h0050, 16'h8000, -13056, 16'hFFF9};

    rst = 1'b1; vld = 1'b0; cal_req = 1'b0; ptch_rt = '0; AZ = '0;
    idle(2);
    check("rst_ptch", 32'(ptch), 32'h0);
    check("rst_ptch_vld", 32'(ptch_vld), 32'h0);
    check("rst_cal_done", 32'(cal_done), 32'h0);
    check("rst_sat", 32'(sat), 32'h0);
    check("rst_rt_off", 32'(ptch_rt_off), 32'h0050);
    check("rst_az_off", 32'(AZ_off), 32'h00A0);
    rst = 1'b0;

    // First calibration: four identical samples become the offsets.
    seen_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("cal1_not_done_early", 32'(cal_done), 32'h0);
      pulse_vld(16'h0058, 16'h00A4);
      seen_vld |= ptch_vld;
      check("cal1_ptch_zero", 32'(ptch), 32'h0);
    end
    check("cal1_no_ptch_vld", 32'(seen_vld), 32'h0);
    check("cal1_done", 32'(cal_done), 32'h1);
    check("cal1_rt_off", 32'(ptch_rt_off), 32'h0058);
    check("cal1_az_off", 32'(AZ_off), 32'h00A4);

    // Restart, then drop a sample that collides with a second cal_req at count 3.
    pulse_cal_req(1'b0);
    check("recal_done_low", 32'(cal_done), 32'h0);
    check("recal_rt_off_kept", 32'(ptch_rt_off), 32'h0058);
    for (int i = 0; i < 3; i++) pulse_vld(16'h0050, 16'h00A0);
    pulse_cal_req(1'b1);
    check("drop_done_low", 32'(cal_done), 32'h0);
    check("drop_ptch_vld", 32'(ptch_vld), 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        check("drop_not_done_early", 32'(cal_done), 32'h0);
        check("drop_az_off_kept", 32'(AZ_off), 32'h00A4);
      end
      pulse_vld(16'h0050, 16'h00A0);
    end
    check("cal2_done", 32'(cal_done), 32'h1);
    check("cal2_rt_off", 32'(ptch_rt_off), 32'h0050);
    check("cal2_az_off", 32'(AZ_off), 32'h00A0);
    check("cal2_acc_clear", acc_now(), 32'h0);

    foreach (vecs[i]) begin
      pulse_vld(vecs[i].rt, vecs[i].az);
      check($sformatf("vec%0d_acc", i), acc_now(), 32'(vecs[i].acc));
      check($sformatf("vec%0d_ptch", i), 32'(ptch), 32'(vecs[i].ptch));
      check($sformatf("vec%0d_ptch_vld", i), 32'(ptch_vld), 32'h1);
      check($sformatf("vec%0d_sat", i), 32'(sat), 32'h0);
      idle(1);
      check($sformatf("vec%0d_vld_pulse", i), 32'(ptch_vld), 32'h0);
    end

    // Quiet period: everything holds.
    held = ptch;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      if (ptch !== held || ptch_vld !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", 32'(bad), 32'h0);
    check("idle_ptch", 32'(ptch), 32'h0000FFF9);

    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_ptch", 32'(ptch), 32'h0);
    check("midrst_cal_done", 32'(cal_done), 32'h0);
    check("midrst_rt_off", 32'(ptch_rt_off), 32'h0050);
    check("midrst_az_off", 32'(AZ_off), 32'h00A0);

    for (int i = 0; i < 4; i++) pulse_vld(16'h0050, 16'h00A0);
    check("cal3_done", 32'(cal_done), 32'h1);

    // Positive saturation: +31744 per sample, clamps on sample 2115.
    seen_sat = 1'b0;
    for (int i = 0; i < 2114; i++) begin
      pulse_vld(16'h8050, 16'h00A0);
      seen_sat |= sat;
    end
    check("sat_not_early", 32'(seen_sat), 32'h0);
    check("sat_pre_acc", acc_now(), 32'd67106816);
    check("sat_pre_ptch", 32'(ptch), 32'h7FFF);
    pulse_vld(16'h8050, 16'h00A0);
    check("sat_pulse", 32'(sat), 32'h1);
    check("sat_acc", acc_now(), 32'h03FFFFFF);
    check("sat_ptch", 32'(ptch), 32'h7FFF);
    idle(1);
    check("sat_pulse_end", 32'(sat), 32'h0);
    pulse_vld(16'h8050, 16'h00A0);
    check("sat_again", 32'(sat), 32'h1);
    check("sat_no_wrap", 32'(ptch), 32'h7FFF);

    // cal_req beats vld in RUN.
    pulse_cal_req(1'b1);
    check("runreq_ptch", 32'(ptch), 32'h0);
    check("runreq_ptch_vld", 32'(ptch_vld), 32'h0);
    check("runreq_cal_done", 32'(cal_done), 32'h0);
    check("runreq_rt_off", 32'(ptch_rt_off), 32'h0050);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
